// File: rtl/wb_sevenseg_mux.sv
// Wishbone slave that time-multiplexes up to 16 seven-segment digits with
// per-digit blanking, decimal points, hex or raw segment source and PWM dimming.
module wb_sevenseg_mux #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst_n,
    input  logic [31:0]       i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic [DIGITS-1:0] o_an,
    output logic [6:0]        o_ca,
    output logic              o_dp
);

    localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]      IDX_LAST   = 4'(DIGITS - 1);

    // Storable bits of each register word; everything else is dropped on write.
    function automatic logic [31:0] word_mask(input int w);
        logic [31:0] m;
        m = '0;
        for (int d = 0; d < 16; d++) begin
            if (d < DIGITS) begin
                case (w)
                    0: m[16+d] = 1'b1;
                    1: if (d < 8) m[4*d +: 4] = 4'hF;
                    2: if (d >= 8) m[4*(d-8) +: 4] = 4'hF;
                    3: m[d] = 1'b1;
                    default: if ((d / 4) == (w - 4)) m[8*(d%4) +: 7] = 7'h7F;
                endcase
            end
        end
        if (w == 0) m[7:0] = 8'hF3;
        return m;
    endfunction

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    localparam logic [31:0] MASK [8] = '{word_mask(0), word_mask(1), word_mask(2), word_mask(3),
                                         word_mask(4), word_mask(5), word_mask(6), word_mask(7)};

    logic [31:0]   regs [8];
    logic          ack_q;
    logic [31:0]   rdt_q;
    logic [2:0]    widx;
    logic          req;
    logic          wr;
    logic [31:0]   be;
    logic          unused_adr;

    assign widx       = i_wb_adr[4:2];
    assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};
    assign req        = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr         = req & i_wb_we;
    assign be         = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

    // Bus stage: ack is the registered request, so it can never stay high two cycles.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            for (int w = 0; w < 8; w++) regs[w] <= '0;
            ack_q <= 1'b0;
            rdt_q <= '0;
        end else begin
            ack_q <= req;
            rdt_q <= req ? regs[widx] : '0;
            if (wr) regs[widx] <= ((regs[widx] & ~be) | (i_wb_dat & be)) & MASK[widx];
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;

    logic          en_q;
    logic          en_kill;
    logic [PW-1:0] presc;
    logic [3:0]    idx;
    logic [3:0]    pwm;

    assign en_q    = regs[0][0];
    assign en_kill = wr & (widx == 3'd0) & i_wb_sel[0] & ~i_wb_dat[0];

    // Scan counters hold at zero while disabled, including the edge that clears EN.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n || !en_q || en_kill) begin
            presc <= '0;
            idx   <= '0;
            pwm   <= '0;
        end else begin
            pwm <= pwm + 4'd1;
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    logic [63:0]       val_all;
    logic [127:0]      raw_all;
    logic [15:0]       blank_vec;
    logic [15:0]       dp_vec;
    logic              lit_p0;
    logic [6:0]        seg_p0;
    logic [DIGITS-1:0] an_p0;

    assign val_all   = {regs[2], regs[1]};
    assign raw_all   = {regs[7], regs[6], regs[5], regs[4]};
    assign blank_vec = regs[0][31:16];
    assign dp_vec    = regs[3][15:0];

    // Select stage: prescaler 0 is the anti-ghost dead cycle.
    always_comb begin
        lit_p0 = en_q & ~blank_vec[idx] & (presc != '0) & (pwm <= regs[0][7:4]);
        seg_p0 = regs[0][1] ? raw_all[{idx, 3'b000} +: 7] : hex_decode(val_all[{idx, 2'b00} +: 4]);
        an_p0  = '1;
        for (int d = 0; d < DIGITS; d++) an_p0[d] = ~(lit_p0 & (idx == 4'(d)));
    end

    logic [DIGITS-1:0] an_p1;
    logic [6:0]        ca_p1;
    logic              dp_p1;

    // Pin stage: all drive is registered to keep the pads glitch-free.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            an_p1 <= '1;
            ca_p1 <= 7'h7F;
            dp_p1 <= 1'b1;
        end else begin
            an_p1 <= an_p0;
            ca_p1 <= lit_p0 ? ~seg_p0 : 7'h7F;
            dp_p1 <= lit_p0 ? ~dp_vec[idx] : 1'b1;
        end
    end

    assign o_an = an_p1;
    assign o_ca = ca_p1;
    assign o_dp = dp_p1;

endmodule

// File: doc/wb_sevenseg_mux.md
# wb_sevenseg_mux

Parametrised Wishbone seven-segment display controller: the next-generation successor to the fixed 8-digit SoC display peripheral. It time-multiplexes up to 16 digits and supports per-digit blanking, decimal points, hex-decode or raw-segment mode, and PWM brightness control. It sits on the SoC Wishbone data bus as a slave, alongside the GPIO and UART slaves, and drives the board anode and cathode pins directly.

## Interface
- DIGITS, 8: number of multiplexed digits, legal range 1..16.
- REFRESH_DIV, 100000: clock cycles per digit slot, minimum 16.

- i_wb_clk  in  1  system/Wishbone clock; sole clock.
- i_wb_rst_n  in  1  reset; synchronous, active-low.
- i_wb_adr  in  32  byte address; only [4:2] decoded.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables for writes.
- i_wb_we  in  1  write strobe.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  slave select.
- o_wb_rdt  out  32  read data, valid while o_wb_ack=1.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_an  out  DIGITS  anodes, active-low, one-hot-low or all-high.
- o_ca  out  7  cathodes a..g on bits [0]..[6], active-low.
- o_dp  out  1  decimal point, active-low.

## Operation
- Register map, word index = i_wb_adr[4:2]:
  - 0 CTRL: [0] EN; [1] RAW (0 = hex decode, 1 = raw); [7:4] BRIGHT; [31:16] BLANK mask.
  - 1 VAL_LO: nibble d holds digit d, for d = 0..7.
  - 2 VAL_HI: nibble d-8 holds digit d, for d = 8..15.
  - 3 DP: [15:0] decimal-point mask.
  - 4..7 RAW0..RAW3: byte (d mod 4) of RAW(d/4) holds segments [6:0] for digit d.
- Register behaviour:
  - Writes honour i_wb_sel per byte.
  - Storage bits belonging to digits ≥ DIGITS, and all reserved bits, are not stored and read 0. This covers RAW byte bit 7 and CTRL [15:8], [3:2].
- Wishbone handshake:
  - A request is i_wb_cyc & i_wb_stb & !o_wb_ack.
  - The write commits at the same edge that raises o_wb_ack.
  - o_wb_ack is high for exactly one cycle and then drops, even if stb stays high. Back-to-back accesses therefore take 2 cycles each.
  - No wait states. No error response.
- Scan engine:
  - Runs only while EN=1.
  - Prescaler counts 0..REFRESH_DIV-1. At terminal count, digit index advances, wrapping DIGITS-1 → 0.
  - The 4-bit PWM counter increments every cycle.
  - Clearing EN resets prescaler, digit index and PWM counter to 0 at the same edge.
- Digit drive for current digit d:
  - Lit = EN & !BLANK[d] & (prescaler ≠ 0) & (pwm ≤ BRIGHT). Prescaler = 0 is the one-cycle anti-ghost dead time.
  - When lit, o_an[d]=0. All other anodes are 1 at all times.
  - Segments: hex mode uses the decode table below; RAW mode uses RAW byte d [6:0]. o_ca is the inverse of the active-high pattern.
  - o_dp = !DP[d].
  - When not lit: o_an all 1, o_ca = 7'h7F, o_dp = 1.
- Hex decode, active-high gfedcba:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07
  - 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71

## Timing
- Reset (i_wb_rst_n=0 at an edge) clears:
  - all registers;
  - prescaler, digit index and PWM counter;
  - o_wb_ack=0, o_wb_rdt=0, o_an all 1, o_ca=7'h7F, o_dp=1.
- Reset mid-transaction drops ack. The aborted write is not committed.
- o_an, o_ca and o_dp are registered: they reflect register and counter state one edge later.
  - A register write committed at edge N is visible on the pins at edge N+1.
  - A write to the currently lit digit takes effect at N+1 with no tearing beyond that cycle.
- Read data is sampled from registers at the ack edge. A read in the cycle after a write returns the new value.
- BRIGHT=15 gives full duty, minus the dead cycle. BRIGHT=0 gives a 1/16 duty.
- DIGITS=1: the index stays at 0, and o_an[0] pulses low once per REFRESH_DIV cycles, gated by PWM.

## Test plan
- Reset: hold i_wb_rst_n=0 for 3 cycles → o_an all 1, o_ca=7F, o_dp=1, ack=0. Read every register → 0.
- Hex scan (DIGITS=8, REFRESH_DIV=16):
  - Stimulus: write VAL_LO=0x76543210, CTRL=0xF1.
  - Required: digits lit in order 0..7, then wrap to 0. Digit 3 shows o_ca=7'h30 (pattern 4F inverted).
  - Required: the dead cycle at prescaler 0 has o_an all 1.
- Byte enables and readback:
  - Stimulus: write VAL_LO=0xFFFFFFFF with sel=4'b0010.
  - Required: read returns 0x0000FF00. Ack is high exactly 1 cycle, and is not reasserted while stb is held.
- Raw, blank and DP:
  - Stimulus: CTRL=0x0004_00F3 (digit 2 blanked), RAW0=0x00_00_49_7F, DP=0x0001.
  - Required: digit 0 has o_ca=00, o_dp=0. Digit 1 has o_ca=36, o_dp=1. Digit 2 slot has o_an all 1.
- Brightness:
  - Stimulus: BRIGHT=3.
  - Required: o_an[d] is low for 4 of every 16 cycles within a slot.
- Disable mid-scan: clear EN at digit 5 → next edge o_an all 1. Re-enable → scan restarts at digit 0, prescaler 0.
